integral_image_gen: RTL



---
 rtl/ii_pkg.sv | 31 +++
 rtl/ii_line_buffer.sv | 29 ++
 rtl/integral_image_gen.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ii_pkg.sv
// Shared constants and state encoding for the integral-image pipeline.
// The Haar classifiers import the same package so buffer geometry and data
// widths stay consistent across producer and consumers.
package ii_pkg;

  // Frame geometry and datapath widths
  localparam int II_WIDTH  = 160;  // pixels per row
  localparam int II_HEIGHT = 120;  // rows per frame
  localparam int PIX_W     = 4;    // unsigned grayscale pixel
  localparam int II_W      = 21;   // signed integral value, always >= 0
  localparam int ADDR_W    = 15;   // integral-image buffer address

  // Derived widths: a row sum peaks at 160*15 = 2400, which needs 12 bits
  localparam int ROW_W     = 12;
  localparam int X_W       = $clog2(II_WIDTH);
  localparam int Y_W       = $clog2(II_HEIGHT);
  localparam int FRAME_PIX = II_WIDTH * II_HEIGHT;

  // One-hot frame sequencing states
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    ACCUM = 3'b010,
    DONE  = 3'b100
  } ii_state_e;

  // Zero-extend a row sum to the integral width
  function automatic logic [II_W-1:0] zext_row(input logic [ROW_W-1:0] v);
    return {{(II_W-ROW_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/ii_line_buffer.sv
// One-row store of integral values: holds II(x, y-1) for every column x so
// the current row can add the column total accumulated above it.
// Combinational read, synchronous write; reading and writing the same column
// in one cycle returns the previous row's value.
module ii_line_buffer
  import ii_pkg::*;
(
  input  logic            clk,
  input  logic [X_W-1:0]  rd_x,
  output logic [II_W-1:0] rd_data,
  input  logic            wr_en,
  input  logic [X_W-1:0]  wr_x,
  input  logic [II_W-1:0] wr_data
);

  logic [II_W-1:0] mem [II_WIDTH];

  assign rd_data = mem[rd_x];

  // Column write of the freshly computed integral value
  // NOTE: storage arrays get no reset; row 0 never reads them, and a reset
  // would force flops where a RAM or LUT array is wanted.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_x] <= wr_data;
    end
  end

endmodule

// File: rtl/integral_image_gen.sv
// Raster-order integral-image generator feeding the shared II buffer.
// Each accepted pixel produces one buffer write one cycle later, with
// II(x,y) = row_sum(x,y) + II(x,y-1).  frame_done pulses the cycle after the
// last write of a frame; frame_err pulses when a frame_start interrupts a frame.
// Optional build macro II_FRAME_DROP_EN: a frame whose frame_start arrives
// while det_busy is high is ignored entirely, so the buffer stays untouched
// during detection.  Without the macro det_busy has no effect.
module integral_image_gen
  import ii_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pixel_valid,
  input  logic                   frame_start,
  input  logic [PIX_W-1:0]       pixel,
  input  logic                   det_busy,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic signed [II_W-1:0] wr_data,
  output logic                   frame_done,
  output logic                   frame_err
);

  localparam logic [X_W-1:0] X_LAST = X_W'(II_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(II_HEIGHT - 1);

  ii_state_e         state_q, state_d;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ROW_W-1:0]  row_sum_q;

  logic              start_req;  // frame_start presented with a pixel
  logic              start_ok;   // that frame is actually going to be built
  logic              accept;     // pixel is written this cycle
  logic              restart;    // pixel is (0,0) of a new frame
  logic              abort;      // running frame interrupted by frame_start
  logic              last_pix;   // pixel is (II_WIDTH-1, II_HEIGHT-1)
  logic [X_W-1:0]    cur_x;
  logic [Y_W-1:0]    cur_y;
  logic [ADDR_W-1:0] cur_addr;
  logic [ROW_W-1:0]  row_sum_d;
  logic [II_W-1:0]   ii_d;
  logic [II_W-1:0]   above;

  assign start_req = pixel_valid && frame_start;

`ifdef II_FRAME_DROP_EN
  assign start_ok = start_req && !det_busy;
`else
  assign start_ok = start_req;
  logic unused_det_busy;
  assign unused_det_busy = det_busy;
`endif

  ii_line_buffer u_line_buf (
    .clk     (clk),
    .rd_x    (cur_x),
    .rd_data (above),
    .wr_en   (accept),
    .wr_x    (cur_x),
    .wr_data (ii_d)
  );

  // Pixel qualification, coordinate selection, arithmetic and next state
  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    restart  = 1'b0;
    abort    = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          accept  = 1'b1;
          restart = 1'b1;
        end
      end
      ACCUM: begin
        if (pixel_valid) begin
          if (start_req) begin
            abort = 1'b1;
            if (start_ok) begin
              accept  = 1'b1;
              restart = 1'b1;
            end
          end else begin
            accept = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // A restarting pixel is (0,0) regardless of where the counters stand
    cur_x    = restart ? '0 : x_q;
    cur_y    = restart ? '0 : y_q;
    cur_addr = restart ? '0 : addr_q;

    row_sum_d = ((cur_x == '0) ? '0 : row_sum_q) + ROW_W'(pixel);
    ii_d      = zext_row(row_sum_d) + ((cur_y == '0) ? '0 : above);
    last_pix  = accept && (cur_x == X_LAST) && (cur_y == Y_LAST);

    unique case (state_q)
      IDLE, DONE: begin
        if (accept) state_d = last_pix ? DONE : ACCUM;
        else        state_d = IDLE;
      end
      ACCUM: begin
        if (abort && !accept) state_d = IDLE;
        else if (last_pix)    state_d = DONE;
        else                  state_d = ACCUM;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered write/pulse outputs
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      row_sum_q  <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_en      <= accept;
      frame_err  <= abort;
      frame_done <= (state_q == DONE);
      if (accept) begin
        wr_addr   <= cur_addr;
        wr_data   <= ii_d;
        row_sum_q <= row_sum_d;
        addr_q    <= last_pix ? '0 : cur_addr + 1'b1;
        if (cur_x == X_LAST) begin
          x_q <= '0;
          y_q <= (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
        end else begin
          x_q <= cur_x + 1'b1;
          y_q <= cur_y;
        end
      end
    end
  end

endmodule
